// File: rtl/matmul_job_scheduler_if.sv
// matmul_job_scheduler_if
//   Bundles the scheduler's three channels into one interface:
//   - job_*  : descriptor offer from the host (valid/ready handshake)
//   - eng_*  : start pulse and dimensions to the engine, done pulse back
//   - cmp_*  : completion record to the host (valid/ready handshake)
//   - busy, queue_level : status
//   master : host/engine side (drives job_*, cmp_ready, eng_done)
//   slave  : scheduler side
interface matmul_job_scheduler_if #(
  parameter int MAX_M      = 100,
  parameter int MAX_K      = 100,
  parameter int MAX_N      = 100,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 4,
  parameter int CYC_W      = 32
);
  localparam int M_W = $clog2(MAX_M) + 1;
  localparam int K_W = $clog2(MAX_K) + 1;
  localparam int N_W = $clog2(MAX_N) + 1;
  localparam int L_W = $clog2(FIFO_DEPTH + 1);

  logic            job_valid;
  logic            job_ready;
  logic [ID_W-1:0] job_id;
  logic [M_W-1:0]  job_m;
  logic [K_W-1:0]  job_k;
  logic [N_W-1:0]  job_n;

  logic            eng_start;
  logic            eng_done;
  logic [M_W-1:0]  eng_m;
  logic [K_W-1:0]  eng_k;
  logic [N_W-1:0]  eng_n;

  logic             cmp_valid;
  logic             cmp_ready;
  logic [ID_W-1:0]  cmp_id;
  logic             cmp_err;
  logic [CYC_W-1:0] cmp_cycles;

  logic            busy;
  logic [L_W-1:0]  queue_level;

  modport master (
    output job_valid, job_id, job_m, job_k, job_n, eng_done, cmp_ready,
    input  job_ready, eng_start, eng_m, eng_k, eng_n,
           cmp_valid, cmp_id, cmp_err, cmp_cycles, busy, queue_level
  );

  modport slave (
    input  job_valid, job_id, job_m, job_k, job_n, eng_done, cmp_ready,
    output job_ready, eng_start, eng_m, eng_k, eng_n,
           cmp_valid, cmp_id, cmp_err, cmp_cycles, busy, queue_level
  );
endinterface

// File: rtl/matmul_job_scheduler.sv
// matmul_job_scheduler
//   Queues matmul job descriptors and runs them one at a time on the shared
//   engine: single-cycle start, dimensions held while running, one
//   completion record per job (id, error flag, saturating run-cycle count).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : matmul_job_scheduler_if.slave (job_*, eng_*, cmp_*, busy, queue_level)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a queued descriptor; pops the head when present
// S_CHECK  | range-checking the latched dimensions
// S_START  | eng_start high for this single cycle; counter cleared
// S_RUN    | counting engine cycles until eng_done
// S_REPORT | completion record offered until cmp_ready
module matmul_job_scheduler #(
  parameter int MAX_M      = 100,
  parameter int MAX_K      = 100,
  parameter int MAX_N      = 100,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 4,
  parameter int CYC_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  matmul_job_scheduler_if.slave   bus
);
  localparam int M_W = $clog2(MAX_M) + 1;
  localparam int K_W = $clog2(MAX_K) + 1;
  localparam int N_W = $clog2(MAX_N) + 1;
  localparam int L_W = $clog2(FIFO_DEPTH + 1);
  localparam int P_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_RUN,
    S_REPORT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ID_W-1:0] r_fifo_id [FIFO_DEPTH];
  logic [M_W-1:0]  r_fifo_m  [FIFO_DEPTH];
  logic [K_W-1:0]  r_fifo_k  [FIFO_DEPTH];
  logic [N_W-1:0]  r_fifo_n  [FIFO_DEPTH];
  logic [P_W-1:0]  r_wr_ptr;
  logic [P_W-1:0]  r_rd_ptr;
  logic [L_W-1:0]  r_level;

  logic [ID_W-1:0]  r_id;
  logic [M_W-1:0]   r_m;
  logic [K_W-1:0]   r_k;
  logic [N_W-1:0]   r_n;
  logic             r_err;
  logic [CYC_W-1:0] r_cnt;

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_legal;

  // job_ready comes only from the registered level, never from cmp/eng inputs
  assign w_ready = (r_level != L_W'(FIFO_DEPTH));
  assign w_push  = bus.job_valid && w_ready;
  assign w_pop   = (r_state == S_IDLE) && (r_level != '0);

  assign w_legal = (r_m != '0) && (r_m <= M_W'(MAX_M)) &&
                   (r_k != '0) && (r_k <= K_W'(MAX_K)) &&
                   (r_n != '0) && (r_n <= N_W'(MAX_N));

  // Storage has no reset; the pointer/level reset is what flushes the queue.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr] <= bus.job_id;
      r_fifo_m[r_wr_ptr]  <= bus.job_m;
      r_fifo_k[r_wr_ptr]  <= bus.job_k;
      r_fifo_n[r_wr_ptr]  <= bus.job_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + P_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + P_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + L_W'(1);
        2'b01:   r_level <= r_level - L_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_next = S_CHECK;
      S_CHECK:  w_next = w_legal ? S_START : S_REPORT;
      S_START:  w_next = S_RUN;
      S_RUN:    if (bus.eng_done) w_next = S_REPORT;
      S_REPORT: if (bus.cmp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Job registers double as the engine dimension outputs, so they only
  // change on the pop and stay put for the rest of the job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id  <= '0;
      r_m   <= '0;
      r_k   <= '0;
      r_n   <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_id <= r_fifo_id[r_rd_ptr];
        r_m  <= r_fifo_m[r_rd_ptr];
        r_k  <= r_fifo_k[r_rd_ptr];
        r_n  <= r_fifo_n[r_rd_ptr];
      end
      case (r_state)
        S_CHECK: begin
          r_err <= !w_legal;
          r_cnt <= '0;
        end
        S_START: r_cnt <= '0;
        // counts the done cycle too, so the count equals the RUN cycles
        S_RUN:   if (r_cnt != '1) r_cnt <= r_cnt + CYC_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.job_ready   = w_ready;
  assign bus.eng_start   = (r_state == S_START);
  assign bus.eng_m       = r_m;
  assign bus.eng_k       = r_k;
  assign bus.eng_n       = r_n;
  assign bus.cmp_valid   = (r_state == S_REPORT);
  assign bus.cmp_id      = r_id;
  assign bus.cmp_err     = r_err;
  assign bus.cmp_cycles  = r_cnt;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.queue_level = r_level;
endmodule

// File: tb/tb_matmul_job_scheduler.sv
module tb_matmul_job_scheduler;
  localparam int MAX_M = 100;
  localparam int MAX_K = 100;
  localparam int MAX_N = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_job_scheduler_if u_if ();
  matmul_job_scheduler_if #(.CYC_W(4)) u_if4 ();

  matmul_job_scheduler u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));
  matmul_job_scheduler #(.CYC_W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct { logic [3:0] id; logic err; logic [31:0] cycles; } cmp_t;
  typedef struct { logic [7:0] m; logic [7:0] k; logic [7:0] n; } dim_t;
  cmp_t exp_q[$];
  dim_t eng_q[$];

  // engine model: done pulse eng_delay cycles after the start cycle
  int   eng_delay   = 20;
  logic model_done  = 1'b0;
  logic extra_done  = 1'b0;
  bit   eng_run     = 1'b0;
  int   eng_left    = 0;
  assign u_if.eng_done = model_done | extra_done;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (rst) begin
      eng_run <= 1'b0;
    end else if (u_if.eng_start) begin
      eng_run  <= 1'b1;
      eng_left <= eng_delay - 1;
    end else if (eng_run) begin
      if (eng_left <= 1) begin
        model_done <= 1'b1;
        eng_run    <= 1'b0;
      end else begin
        eng_left <= eng_left - 1;
      end
    end
  end

  int   n_start = 0;
  int   n_cmp   = 0;
  int   s_cyc   = 0;
  int   c_cyc   = 0;
  logic prev_start = 1'b0;
  dim_t cur;

  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.eng_start) begin
        check_val("start_width", prev_start, 0);
        n_start++;
        s_cyc = cyc;
        if (eng_q.size() == 0) begin
          check_val("unexpected_start", 1, 0);
        end else begin
          cur = eng_q.pop_front();
          check_val("eng_m_start", u_if.eng_m, cur.m);
          check_val("eng_k_start", u_if.eng_k, cur.k);
          check_val("eng_n_start", u_if.eng_n, cur.n);
        end
      end
      if (model_done && u_if.busy) begin
        check_val("eng_m_done", u_if.eng_m, cur.m);
        check_val("eng_k_done", u_if.eng_k, cur.k);
        check_val("eng_n_done", u_if.eng_n, cur.n);
      end
      if (u_if.cmp_valid && u_if.cmp_ready) begin
        cmp_t e;
        n_cmp++;
        c_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_val("unexpected_cmp", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("cmp_id", u_if.cmp_id, e.id);
          check_val("cmp_err", u_if.cmp_err, e.err);
          check_val("cmp_cycles", u_if.cmp_cycles, e.cycles);
        end
      end
    end
    prev_start = u_if.eng_start;
  end

  int t_acc = 0;

  task automatic push_job(input logic [3:0] id, input logic [7:0] m, input logic [7:0] k,
                          input logic [7:0] n);
    int   guard;
    cmp_t e;
    dim_t d;
    bit   legal;
    @(posedge clk); #1;
    u_if.job_id    = id;
    u_if.job_m     = m;
    u_if.job_k     = k;
    u_if.job_n     = n;
    u_if.job_valid = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if (u_if.job_ready) break;
      guard++;
      if (guard > 500) begin
        check_val("push_timeout", 1, 0);
        break;
      end
    end
    t_acc = cyc;
    legal = (m >= 1) && (m <= MAX_M) && (k >= 1) && (k <= MAX_K) && (n >= 1) && (n <= MAX_N);
    e.id     = id;
    e.err    = !legal;
    e.cycles = legal ? eng_delay : 0;
    exp_q.push_back(e);
    if (legal) begin
      d.m = m; d.k = k; d.n = n;
      eng_q.push_back(d);
    end
    @(posedge clk); #1;
    u_if.job_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !u_if.busy && u_if.queue_level == 0) break;
      guard++;
      if (guard > 3000) begin
        check_val(tag, 1, 0);
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t5, t6, n0, nc, guard;
    u_if.job_valid = 1'b0; u_if.job_id = '0; u_if.job_m = '0; u_if.job_k = '0; u_if.job_n = '0;
    u_if.cmp_ready = 1'b1;
    u_if4.job_valid = 1'b0; u_if4.job_id = '0; u_if4.job_m = '0; u_if4.job_k = '0;
    u_if4.job_n = '0; u_if4.cmp_ready = 1'b1; u_if4.eng_done = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_job_ready", u_if.job_ready, 1);
    check_val("rst_eng_start", u_if.eng_start, 0);
    check_val("rst_cmp_valid", u_if.cmp_valid, 0);
    check_val("rst_busy", u_if.busy, 0);
    check_val("rst_level", u_if.queue_level, 0);
    check_val("rst_eng_m", u_if.eng_m, 0);
    check_val("rst_cmp_cycles", u_if.cmp_cycles, 0);
    check_val("rst4_job_ready", u_if4.job_ready, 1);
    @(posedge clk); #1; rst = 1'b0;

    // single legal job, done 20 cycles after start
    eng_delay = 20;
    n0 = n_start;
    push_job(4'd3, 8'd2, 8'd3, 8'd2);
    check_val("level_T1", u_if.queue_level, 1);
    wait_idle("t1_timeout");
    check_val("t1_start_lat", s_cyc - t_acc, 3);
    check_val("t1_cmp_lat", c_cyc - t_acc, 24);
    check_val("t1_starts", n_start - n0, 1);

    // illegal jobs: k=0, then m=MAX_M+1
    n0 = n_start;
    push_job(4'd5, 8'd2, 8'd0, 8'd2);
    t5 = t_acc;
    wait_idle("t2a_timeout");
    check_val("t2_err_lat5", c_cyc - t5, 3);
    push_job(4'd6, 8'(MAX_M + 1), 8'd2, 8'd2);
    t6 = t_acc;
    wait_idle("t2b_timeout");
    check_val("t2_err_lat6", c_cyc - t6, 3);
    check_val("t2_no_start", n_start - n0, 0);

    // stall completions and fill the queue
    eng_delay = 5;
    nc = n_cmp;
    u_if.cmp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_job(4'(i), 8'(i + 1), 8'd2, 8'd3);
    check_val("full_ready", u_if.job_ready, 0);
    check_val("full_level", u_if.queue_level, 4);
    check_val("full_cmp_valid", u_if.cmp_valid, 1);
    u_if.cmp_ready = 1'b1;
    wait_idle("t3_timeout");
    check_val("t3_ncmp", n_cmp - nc, 5);

    // stray eng_done in IDLE and in REPORT
    nc = n_cmp;
    @(posedge clk); #1; extra_done = 1'b1;
    @(posedge clk); #1; extra_done = 1'b0;
    repeat (3) @(negedge clk);
    check_val("idle_done_busy", u_if.busy, 0);
    check_val("idle_done_cmp", u_if.cmp_valid, 0);
    u_if.cmp_ready = 1'b0;
    push_job(4'd9, 8'd4, 8'd4, 8'd4);
    guard = 0;
    while (!u_if.cmp_valid && guard < 200) begin @(negedge clk); guard++; end
    check_val("rep_reached", u_if.cmp_valid, 1);
    @(posedge clk); #1; extra_done = 1'b1;
    @(posedge clk); #1; extra_done = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rep_done_valid", u_if.cmp_valid, 1);
    check_val("rep_done_id", u_if.cmp_id, 9);
    u_if.cmp_ready = 1'b1;
    wait_idle("t4_timeout");
    repeat (3) @(negedge clk);
    check_val("t4_ncmp", n_cmp - nc, 1);

    // saturation on the CYC_W=4 instance
    @(posedge clk); #1;
    u_if4.job_id = 4'd7; u_if4.job_m = 8'd2; u_if4.job_k = 8'd2; u_if4.job_n = 8'd2;
    u_if4.job_valid = 1'b1;
    @(posedge clk); #1; u_if4.job_valid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!u_if4.eng_start && guard < 50);
    check_val("sat_start", u_if4.eng_start, 1);
    repeat (21) @(posedge clk);
    #1; u_if4.eng_done = 1'b1;
    @(posedge clk); #1; u_if4.eng_done = 1'b0;
    guard = 0;
    while (!u_if4.cmp_valid && guard < 50) begin @(negedge clk); guard++; end
    check_val("sat_cycles", u_if4.cmp_cycles, 15);
    check_val("sat_err", u_if4.cmp_err, 0);
    check_val("sat_id", u_if4.cmp_id, 7);

    // reset while running with two jobs queued
    eng_delay = 50;
    push_job(4'd1, 8'd3, 8'd3, 8'd3);
    push_job(4'd2, 8'd3, 8'd3, 8'd3);
    push_job(4'd3, 8'd3, 8'd3, 8'd3);
    @(negedge clk);
    check_val("pre_rst_busy", u_if.busy, 1);
    check_val("pre_rst_level", u_if.queue_level, 2);
    #1; rst = 1'b1;
    #1;
    check_val("mid_rst_start", u_if.eng_start, 0);
    check_val("mid_rst_cmp", u_if.cmp_valid, 0);
    check_val("mid_rst_level", u_if.queue_level, 0);
    check_val("mid_rst_ready", u_if.job_ready, 1);
    check_val("mid_rst_busy", u_if.busy, 0);
    exp_q.delete();
    eng_q.delete();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    eng_delay = 7;
    nc = n_cmp;
    push_job(4'd4, 8'd5, 8'd6, 8'd7);
    wait_idle("t6_timeout");
    check_val("t6_ncmp", n_cmp - nc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
